// File: rtl/fsm_step_pkg.sv
// Shared state encoding and counter-width helper for the FSM step controller.
package fsm_step_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      STEP = 3'd1,
      HOLD = 3'd2,
      RUN  = 3'd3,
      LOAD = 3'd4
   } ctrl_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int RUN_PERIOD_DEF      = 50000000;

   // Bits needed for a counter that only ever holds 0..n-1.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/step_debounce.sv
// 2-flop synchronizer, stability-count debouncer and rising-edge detect for one
// raw board input.
module step_debounce
   import fsm_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic din_raw,
   output logic db,
   output logic rise
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          db_q, db_d, db_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synced input disagrees with the level.
   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) begin
            db_d  = sync2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= din_raw;
         sync2_q  <= sync1_q;
         db_q     <= db_d;
         db_dly_q <= db_q;
         cnt_q    <= cnt_d;
      end
   end

   assign db   = db_q;
   assign rise = db_q & ~db_dly_q;

endmodule

// File: rtl/fsm_step_ctrl.sv
// Board-side sequencer for the Moore FSM core: debounced single-step, free-run
// at a fixed period, preset load strobe and synchronized FSM input switches.
module fsm_step_ctrl
   import fsm_step_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int RUN_PERIOD      = RUN_PERIOD_DEF,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_step,
   input  logic             btn_preset,
   input  logic             sw_run,
   input  logic [1:0]       sw_raw,
   output logic             fsm_ctrl,
   output logic             fsm_load,
   output logic [1:0]       sw_out,
   output logic [CNT_W-1:0] step_count,
   output logic             busy
);

   localparam int PER_W = cnt_width(RUN_PERIOD);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(RUN_PERIOD - 1);

   logic step_db, step_rise, preset_rise, run_db;
   logic unused_preset_db, unused_run_rise;

   step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
      .clk(clk), .reset(reset), .din_raw(btn_step),   .db(step_db),          .rise(step_rise));
   step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_preset (
      .clk(clk), .reset(reset), .din_raw(btn_preset), .db(unused_preset_db), .rise(preset_rise));
   step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
      .clk(clk), .reset(reset), .din_raw(sw_run),     .db(run_db),           .rise(unused_run_rise));

   logic [1:0] sw_s1_q, sw_s2_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_s1_q <= '0;
         sw_s2_q <= '0;
      end else begin
         sw_s1_q <= sw_raw;
         sw_s2_q <= sw_s1_q;
      end
   end

   assign sw_out = sw_s2_q;

   ctrl_state_t      state_q, state_d;
   logic             fsm_ctrl_q, fsm_ctrl_d;
   logic             fsm_load_q, fsm_load_d;
   logic [CNT_W-1:0] step_count_q, step_count_d;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;

   // Pulses are decided on the transition edge so they appear registered in
   // the first cycle of STEP/LOAD or on the RUN period wrap.
   always_comb begin
      state_d      = state_q;
      fsm_ctrl_d   = 1'b0;
      fsm_load_d   = 1'b0;
      step_count_d = step_count_q;
      per_cnt_d    = per_cnt_q;
      if (preset_rise && (state_q == IDLE || state_q == HOLD || state_q == RUN)) begin
         state_d      = LOAD;
         fsm_load_d   = 1'b1;
         step_count_d = '0;
         per_cnt_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (run_db) begin
                  state_d   = RUN;
                  per_cnt_d = '0;
               end else if (step_rise) begin
                  state_d      = STEP;
                  fsm_ctrl_d   = 1'b1;
                  step_count_d = step_count_q + CNT_W'(1);
               end
            end
            STEP: state_d = HOLD;
            HOLD: begin
               if (!step_db) state_d = IDLE;
            end
            RUN: begin
               if (!run_db) begin
                  state_d   = IDLE;
                  per_cnt_d = '0;
               end else if (per_cnt_q == PER_LAST) begin
                  per_cnt_d    = '0;
                  fsm_ctrl_d   = 1'b1;
                  step_count_d = step_count_q + CNT_W'(1);
               end else begin
                  per_cnt_d = per_cnt_q + PER_W'(1);
               end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         fsm_ctrl_q   <= 1'b0;
         fsm_load_q   <= 1'b0;
         step_count_q <= '0;
         per_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         fsm_ctrl_q   <= fsm_ctrl_d;
         fsm_load_q   <= fsm_load_d;
         step_count_q <= step_count_d;
         per_cnt_q    <= per_cnt_d;
      end
   end

   assign fsm_ctrl   = fsm_ctrl_q;
   assign fsm_load   = fsm_load_q;
   assign step_count = step_count_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// Bench for fsm_step_ctrl: expected pulses are queued when stimulus is driven
// and matched against fsm_ctrl/fsm_load as they appear.
module tb_fsm_step_ctrl;

   localparam int DB  = 4;
   localparam int RP  = 5;
   localparam int CW  = 8;
   localparam int LAT = DB + 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          btn_step = 1'b0, btn_preset = 1'b0, sw_run = 1'b0;
   logic [1:0]    sw_raw = 2'b00;
   logic          fsm_ctrl, fsm_load, busy;
   logic [1:0]    sw_out;
   logic [CW-1:0] step_count;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct { bit is_load; int at; int cnt; } exp_t;
   exp_t exp_q[$];

   typedef struct { int hold; bit pulse; } step_vec_t;
   step_vec_t vecs[5];

   fsm_step_ctrl #(.DEBOUNCE_CYCLES(DB), .RUN_PERIOD(RP), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .btn_step(btn_step), .btn_preset(btn_preset),
      .sw_run(sw_run), .sw_raw(sw_raw), .fsm_ctrl(fsm_ctrl), .fsm_load(fsm_load),
      .sw_out(sw_out), .step_count(step_count), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk_pending();
      chk("pending_pulses", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      btn_step = 1'b0; btn_preset = 1'b0; sw_run = 1'b0; sw_raw = 2'b00;
      tick(3);
      chk_pending();
      reset = 1'b0;
      tick(1);
   endtask

   // Free-run for n pulses; sw_run is dropped so that leaving RUN lands on the
   // edge where pulse n+1 would have been due.
   task automatic run_burst(input int n, input int base);
      int k, d;
      k = cyc;
      sw_run = 1'b1;
      for (int m = 0; m < n; m++)
         exp_q.push_back('{1'b0, k + LAT + RP * (m + 1), (base + m + 1) % 256});
      d = k + RP * (n + 1);
      wait_until(d);
      chk("run_busy", int'(busy), 1);
      sw_run = 1'b0;
      wait_until(d + LAT);
      chk("run_stop_busy", int'(busy), 0);
      wait_until(d + LAT + RP + 5);
      chk_pending();
      chk("run_step_count", int'(step_count), (base + n) % 256);
   endtask

   always @(negedge clk) begin
      if (!reset && (fsm_ctrl || fsm_load)) begin
         chk("ctrl_load_exclusive", int'(fsm_ctrl && fsm_load), 0);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", cyc, -1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.is_load ? "load_pulse_kind" : "ctrl_pulse_kind", int'(fsm_load), int'(e.is_load));
            chk("pulse_cycle", cyc, e.at);
            chk("pulse_step_count", int'(step_count), e.cnt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int k, r, p, d, cnt;
      logic [1:0] prev;

      vecs[0] = '{20, 1'b1};
      vecs[1] = '{3,  1'b0};
      vecs[2] = '{4,  1'b1};
      vecs[3] = '{2,  1'b0};
      vecs[4] = '{10, 1'b1};

      // Reset then idle
      tick(3);
      chk("rst_fsm_ctrl", int'(fsm_ctrl), 0);
      chk("rst_fsm_load", int'(fsm_load), 0);
      chk("rst_step_count", int'(step_count), 0);
      chk("rst_busy", int'(busy), 0);
      reset = 1'b0;
      tick(20);
      chk("idle_fsm_ctrl", int'(fsm_ctrl), 0);
      chk("idle_fsm_load", int'(fsm_load), 0);
      chk("idle_sw_out", int'(sw_out), 0);
      chk("idle_step_count", int'(step_count), 0);
      chk("idle_busy", int'(busy), 0);

      // sw_out: two-cycle synchronizer latency
      prev = 2'b00;
      for (int i = 0; i < 4; i++) begin
         sw_raw = 2'(i * 3 + 2);
         tick(1);
         chk("sw_out_lat1", int'(sw_out), int'(prev));
         tick(1);
         chk("sw_out_lat2", int'(sw_out), int'(sw_raw));
         prev = sw_raw;
      end
      sw_raw = 2'b00;
      tick(3);

      // Single-step table: press lengths around the debounce threshold
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         k = cyc;
         btn_step = 1'b1;
         if (vecs[i].pulse) begin
            cnt = (cnt + 1) % 256;
            exp_q.push_back('{1'b0, k + LAT, cnt});
         end
         tick(vecs[i].hold);
         btn_step = 1'b0;
         r = cyc;
         if (vecs[i].pulse) begin
            wait_until(r + LAT - 1);
            chk("hold_busy", int'(busy), 1);
            wait_until(r + LAT);
            chk("release_busy", int'(busy), 0);
         end
         wait_until(r + 25);
         chk("step_count", int'(step_count), cnt);
         chk("step_idle_busy", int'(busy), 0);
         chk_pending();
      end

      // Bounce rejection
      do_reset();
      for (int i = 0; i < 4; i++) begin
         btn_step = (i % 2 == 0);
         tick(2);
      end
      btn_step = 1'b0;
      tick(25);
      chk("bounce_step_count", int'(step_count), 0);
      chk("bounce_busy", int'(busy), 0);
      chk_pending();

      // Free-run, four pulses, stop suppresses the pulse due on exit
      do_reset();
      run_burst(4, 0);

      // Preset during RUN, landing on the edge a pulse was due
      do_reset();
      k = cyc;
      sw_run = 1'b1;
      for (int m = 0; m < 3; m++)
         exp_q.push_back('{1'b0, k + LAT + RP * (m + 1), m + 1});
      p = k + RP * 4;
      wait_until(p);
      btn_preset = 1'b1;
      exp_q.push_back('{1'b1, p + LAT, 0});
      exp_q.push_back('{1'b0, p + LAT + 2 + RP, 1});
      exp_q.push_back('{1'b0, p + LAT + 2 + 2 * RP, 2});
      wait_until(p + 10);
      btn_preset = 1'b0;
      d = p + 2 + 3 * RP;
      wait_until(d);
      sw_run = 1'b0;
      wait_until(d + LAT);
      chk("preset_run_stop_busy", int'(busy), 0);
      wait_until(d + LAT + 10);
      chk("preset_step_count", int'(step_count), 2);
      chk_pending();

      // Simultaneous preset and step in IDLE
      do_reset();
      k = cyc;
      btn_step = 1'b1;
      btn_preset = 1'b1;
      exp_q.push_back('{1'b1, k + LAT, 0});
      tick(12);
      btn_step = 1'b0;
      btn_preset = 1'b0;
      tick(25);
      chk("simul_busy", int'(busy), 0);
      chk_pending();

      // step_count wrap after 256 pulses
      do_reset();
      run_burst(256, 0);

      // Asynchronous reset in HOLD
      do_reset();
      sw_raw = 2'b11;
      k = cyc;
      btn_step = 1'b1;
      exp_q.push_back('{1'b0, k + LAT, 1});
      wait_until(k + LAT + 2);
      chk("hold_busy_pre", int'(busy), 1);
      chk("hold_sw_out_pre", int'(sw_out), 3);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_fsm_ctrl", int'(fsm_ctrl), 0);
      chk("async_rst_fsm_load", int'(fsm_load), 0);
      chk("async_rst_busy", int'(busy), 0);
      chk("async_rst_step_count", int'(step_count), 0);
      chk("async_rst_sw_out", int'(sw_out), 0);
      btn_step = 1'b0;
      sw_raw = 2'b00;
      tick(3);
      chk_pending();
      reset = 1'b0;
      tick(3);

      // Asynchronous reset during the fsm_ctrl pulse itself
      k = cyc;
      btn_step = 1'b1;
      wait_until(k + LAT - 1);
      @(posedge clk);
      #1 chk("pulse_before_reset", int'(fsm_ctrl), 1);
      reset = 1'b1;
      #1;
      chk("pulse_killed_by_reset", int'(fsm_ctrl), 0);
      chk("pulse_reset_step_count", int'(step_count), 0);
      chk("pulse_reset_busy", int'(busy), 0);
      btn_step = 1'b0;
      tick(3);
      reset = 1'b0;
      tick(25);
      chk("post_reset_busy", int'(busy), 0);
      chk_pending();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
